// File: rtl/nibble_packer_pkg.sv
// Shared definitions for the nibble packer.
//   NIBBLE_W            width of one upstream symbol (4 bits)
//   DEFAULT_WORD_WIDTH  default assembled word width
//   nibble_t            one 4-bit symbol
//   count_width()       width of the slot counter for a given word width
package nibble_packer_pkg;

  localparam int NIBBLE_W           = 4;
  localparam int DEFAULT_WORD_WIDTH = 16;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  // Slot counter width: log2 of the slot count, never narrower than 1 bit.
  function automatic int count_width(input int word_width);
    int slots;
    slots = word_width / NIBBLE_W;
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/nibble_packer_if.sv
// Bus bundle between an upstream nibble source / downstream word sink and
// the packer.
//   master modport: the environment side (drives nibbles, flush, word ready)
//   slave modport : the packer side (drives nibble ready, word, count)
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; the sender holds data and valid stable until that edge, and ready
// may depend combinationally on the other side's valid.
interface nibble_packer_if
  import nibble_packer_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) ();

  localparam int CNT_W = count_width(WORD_WIDTH);

  nibble_t               inNibble;
  logic                  inNibValid;
  logic                  outNibReady;
  logic                  inFlush;
  logic [WORD_WIDTH-1:0] outWord;
  logic                  outWordValid;
  logic                  inWordReady;
  logic [CNT_W-1:0]      outCount;

  modport master (
    output inNibble, inNibValid, inFlush, inWordReady,
    input  outNibReady, outWord, outWordValid, outCount
  );

  modport slave (
    input  inNibble, inNibValid, inFlush, inWordReady,
    output outNibReady, outWord, outWordValid, outCount
  );

endinterface

// File: rtl/nibble_packer_slot_writer.sv
// nibble_slot_writer: combinational write of one nibble into a slot of the
// staging word (the inverse of a nibble-select mux).
//   i_stage  current staging word
//   i_slot   slot index to write
//   i_nibble nibble to place
//   o_stage  staging word with the slot replaced
// Slot mapping: LSB-first (slot k -> bits [4k+3:4k]) by default; with
// NIBBLE_PACKER_MSB_FIRST_EN defined, slot k counts from the MSB instead.
module nibble_slot_writer
  import nibble_packer_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int CNT_W      = count_width(WORD_WIDTH)
) (
  input  logic [WORD_WIDTH-1:0] i_stage,
  input  logic [CNT_W-1:0]      i_slot,
  input  nibble_t               i_nibble,
  output logic [WORD_WIDTH-1:0] o_stage
);

  localparam int SLOTS = WORD_WIDTH / NIBBLE_W;

  always_comb begin
    o_stage = i_stage;
    for (int k = 0; k < SLOTS; k++) begin
      if (i_slot == CNT_W'(k)) begin
`ifdef NIBBLE_PACKER_MSB_FIRST_EN
        o_stage[WORD_WIDTH - NIBBLE_W*(k+1) +: NIBBLE_W] = i_nibble;
`else
        o_stage[NIBBLE_W*k +: NIBBLE_W] = i_nibble;
`endif
      end
    end
  end

endmodule

// File: rtl/nibble_packer.sv
// nibble_packer: assembles WORD_WIDTH/4 consecutive nibbles into one word.
//   inClk    rising-edge clock
//   inReset  synchronous active-high reset
//   bus      nibble_packer_if.slave: nibble in (valid/ready), flush,
//            word out (valid/ready), slot count
// WORD_WIDTH must be a multiple of 4 and at least 8.
// Optional macro NIBBLE_PACKER_MSB_FIRST_EN selects MSB-first slot mapping;
// it changes only where nibbles land, never timing or handshakes.
module nibble_packer
  import nibble_packer_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
  input  logic           inClk,
  input  logic           inReset,
  nibble_packer_if.slave bus
);

  localparam int               SLOTS = WORD_WIDTH / NIBBLE_W;
  localparam int               CNT_W = count_width(WORD_WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(SLOTS - 1);

  logic [WORD_WIDTH-1:0] r_stage;
  logic [CNT_W-1:0]      r_count;
  logic [WORD_WIDTH-1:0] r_word;
  logic                  r_word_valid;

  logic                  w_at_last;
  logic                  w_nib_ready;
  logic                  w_accept;
  logic                  w_complete;
  logic [WORD_WIDTH-1:0] w_stage_next;

  // Only the final slot needs the output register, so only it waits on
  // downstream; the earlier slots fill freely into the staging register.
  assign w_at_last   = (r_count == LAST);
  assign w_nib_ready = !w_at_last || !r_word_valid || bus.inWordReady;
  assign w_accept    = bus.inNibValid && w_nib_ready && !bus.inFlush;
  assign w_complete  = w_accept && w_at_last;

  nibble_slot_writer #(
    .WORD_WIDTH (WORD_WIDTH),
    .CNT_W      (CNT_W)
  ) u_slot_writer (
    .i_stage  (r_stage),
    .i_slot   (r_count),
    .i_nibble (bus.inNibble),
    .o_stage  (w_stage_next)
  );

  always_ff @(posedge inClk) begin
    if (inReset) begin
      r_stage      <= '0;
      r_count      <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      // Staging side: flush wins over a simultaneous nibble.
      if (bus.inFlush) begin
        r_stage <= '0;
        r_count <= '0;
      end else if (w_accept) begin
        if (w_at_last) begin
          r_stage <= '0;
          r_count <= '0;
        end else begin
          r_stage <= w_stage_next;
          r_count <= r_count + 1'b1;
        end
      end

      // Output side: a completing word can only occur when the output is
      // empty or being drained this cycle, so loading it never loses data.
      if (w_complete) begin
        r_word       <= w_stage_next;
        r_word_valid <= 1'b1;
      end else if (r_word_valid && bus.inWordReady) begin
        r_word_valid <= 1'b0;
      end
    end
  end

  assign bus.outNibReady  = w_nib_ready;
  assign bus.outWord      = r_word;
  assign bus.outWordValid = r_word_valid;
  assign bus.outCount     = r_count;

endmodule

// File: tb/tb_nibble_packer.sv
// Self-checking bench for nibble_packer (WORD_WIDTH = 16).
// Stimulus pushes each expected word into exp_q when its last nibble is
// issued; the monitor pops and compares on every output handshake.
module tb_nibble_packer;
  import nibble_packer_pkg::*;

  localparam int WW = 16;

  // Expected words, hand-computed for both slot mappings.
  localparam logic [WW-1:0] E_1234 =
`ifdef NIBBLE_PACKER_MSB_FIRST_EN
    16'h1234;
`else
    16'h4321;
`endif
  localparam logic [WW-1:0] E_0123 =
`ifdef NIBBLE_PACKER_MSB_FIRST_EN
    16'h0123;
`else
    16'h3210;
`endif
  localparam logic [WW-1:0] E_4567 =
`ifdef NIBBLE_PACKER_MSB_FIRST_EN
    16'h4567;
`else
    16'h7654;
`endif
  localparam logic [WW-1:0] E_5A5A =
`ifdef NIBBLE_PACKER_MSB_FIRST_EN
    16'h5A5A;
`else
    16'hA5A5;
`endif
  localparam logic [WW-1:0] E_BCDE =
`ifdef NIBBLE_PACKER_MSB_FIRST_EN
    16'hBCDE;
`else
    16'hEDCB;
`endif
  localparam logic [WW-1:0] E_9ABC =
`ifdef NIBBLE_PACKER_MSB_FIRST_EN
    16'h9ABC;
`else
    16'hCBA9;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nibble_packer_if #(.WORD_WIDTH(WW)) bus ();

  nibble_packer #(.WORD_WIDTH(WW)) dut (
    .inClk   (clk),
    .inReset (rst),
    .bus     (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [WW-1:0] exp_q[$];
  int checks     = 0;
  int errors     = 0;
  int stall_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  // A word transfers on the next rising edge whenever valid&&ready at negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.outWordValid && bus.inWordReady) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {16'h0, bus.outWord}, 32'hFFFF_FFFF);
        end else begin
          check("word", {16'h0, bus.outWord}, {16'h0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_nib(input logic [3:0] n);
    int waits;
    waits = 0;
    bus.inNibble   = n;
    bus.inNibValid = 1'b1;
    @(negedge clk);
    while (!bus.outNibReady && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (waits != 0) stall_cnt++;
    if (!bus.outNibReady) check("nib_accept_timeout", 32'(bus.outNibReady), 32'd1);
    @(posedge clk);
    #1;
    bus.inNibValid = 1'b0;
  endtask

  task automatic send4(input logic [3:0] a, b, c, d);
    send_nib(a);
    send_nib(b);
    send_nib(c);
    send_nib(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_word"},     {16'h0, bus.outWord}, 32'h0);
    check({tag, "_valid"},    32'(bus.outWordValid), 32'd0);
    check({tag, "_count"},    32'(bus.outCount), 32'd0);
    check({tag, "_nibready"}, 32'(bus.outNibReady), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- global time limit ----------------
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int waits;
    bus.inNibble    = '0;
    bus.inNibValid  = 1'b0;
    bus.inFlush     = 1'b0;
    bus.inWordReady = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    check_reset_state("reset");

    // Basic word, one-cycle latency after the 4th nibble.
    exp_q.push_back(E_1234);
    send4(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge clk);
    check("basic_valid_latency", 32'(bus.outWordValid), 32'd1);
    check("basic_count_wrap",    32'(bus.outCount), 32'd0);
    @(negedge clk);
    check("basic_valid_one_cycle", 32'(bus.outWordValid), 32'd0);
    @(posedge clk);
    #1;

    // Continuous stream of 8 nibbles, no stalls expected.
    stall_cnt = 0;
    exp_q.push_back(E_0123);
    send4(4'h0, 4'h1, 4'h2, 4'h3);
    exp_q.push_back(E_4567);
    send4(4'h4, 4'h5, 4'h6, 4'h7);
    check("stream_no_stall", 32'(stall_cnt), 32'd0);
    idle(2);

    // Back-pressure: word pending while three more nibbles still fill.
    bus.inWordReady = 1'b0;
    exp_q.push_back(E_5A5A);
    send4(4'h5, 4'hA, 4'h5, 4'hA);
    send_nib(4'h1);
    send_nib(4'h2);
    send_nib(4'h3);
    @(negedge clk);
    check("bp_count3", 32'(bus.outCount), 32'd3);
    @(posedge clk);
    #1;
    bus.inNibble   = 4'h4;
    bus.inNibValid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_nibready_low", 32'(bus.outNibReady), 32'd0);
      check("bp_word_hold",    {16'h0, bus.outWord}, {16'h0, E_5A5A});
      check("bp_valid_hold",   32'(bus.outWordValid), 32'd1);
      @(posedge clk);
      #1;
    end
    check("bp_count_hold", 32'(bus.outCount), 32'd3);
    exp_q.push_back(E_1234);
    bus.inWordReady = 1'b1;
    @(negedge clk);
    check("bp_nibready_release", 32'(bus.outNibReady), 32'd1);
    @(posedge clk);
    #1;
    bus.inNibValid = 1'b0;
    @(negedge clk);
    check("bp_no_bubble", 32'(bus.outWordValid), 32'd1);
    check("bp_count_wrap", 32'(bus.outCount), 32'd0);
    idle(2);

    // Flush with a simultaneous nibble, which is dropped.
    send_nib(4'h7);
    send_nib(4'h8);
    @(negedge clk);
    check("flush_pre_count", 32'(bus.outCount), 32'd2);
    @(posedge clk);
    #1;
    bus.inNibble   = 4'h9;
    bus.inNibValid = 1'b1;
    bus.inFlush    = 1'b1;
    @(posedge clk);
    #1;
    bus.inNibValid = 1'b0;
    bus.inFlush    = 1'b0;
    @(negedge clk);
    check("flush_count", 32'(bus.outCount), 32'd0);
    check("flush_no_word", 32'(bus.outWordValid), 32'd0);
    @(posedge clk);
    #1;
    exp_q.push_back(E_BCDE);
    send4(4'hB, 4'hC, 4'hD, 4'hE);
    idle(2);

    // Reset mid-word.
    send_nib(4'h1);
    send_nib(4'h2);
    do_reset();
    check_reset_state("rst_midword");

    // Reset with an output pending (that word is discarded, never expected).
    bus.inWordReady = 1'b0;
    send4(4'h3, 4'h3, 4'h3, 4'h3);
    send_nib(4'h6);
    do_reset();
    check_reset_state("rst_pending");
    bus.inWordReady = 1'b1;
    exp_q.push_back(E_9ABC);
    send4(4'h9, 4'hA, 4'hB, 4'hC);

    // Drain: every expected word must have been seen.
    waits = 0;
    while (exp_q.size() != 0 && waits < 20) begin
      waits++;
      @(posedge clk);
    end
    idle(2);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 16, giving the output word width in bits; it SHALL be a multiple of 4 and at least 8.
REQ-002 inClk  input  1  single clock; every register SHALL update on the rising edge.
REQ-003 inReset  input  1  reset, synchronous to inClk and active-high.
REQ-004 inNibble  input  4  4-bit symbol from upstream.
REQ-005 inNibValid  input  1  inNibble is valid.
REQ-006 outNibReady  output  1  packer accepts inNibble this cycle.
REQ-007 inFlush  input  1  discard the partial word being assembled.
REQ-008 outWord  output  WORD_WIDTH  assembled word.
REQ-009 outWordValid  output  1  outWord is valid.
REQ-010 inWordReady  input  1  downstream accepts outWord.
REQ-011 outCount  output  log2(WORD_WIDTH/4)  index of the next nibble slot to fill.

Function
REQ-012 A nibble SHALL be accepted in any cycle with inNibValid=1, outNibReady=1 and inFlush=0.
REQ-013 An accepted nibble SHALL be written into slot outCount of an internal staging register, and outCount SHALL then increment.
REQ-014 Slot k SHALL occupy bits [4k+3:4k] of the staging register, so the first nibble lands in bits [3:0].
REQ-015 The staging register and the output register SHALL be separate, so a stalled output never blocks filling of slots 0..last-1.
REQ-016 outNibReady SHALL be 1 when outCount != last, or outWordValid=0, or inWordReady=1. It is combinational, with no registered bubble.
REQ-017 When the last slot is accepted, the complete word SHALL load into outWord and outWordValid SHALL be 1 on the next cycle (latency 1 cycle from the final nibble).
REQ-018 On the same edge as REQ-017, outCount SHALL wrap to 0 and the staging register SHALL clear.
REQ-019 While outWordValid=1 and inWordReady=0, outWord and outWordValid SHALL hold stable.
REQ-020 outWordValid SHALL clear after a cycle with outWordValid=1 and inWordReady=1, unless a new word completes in the same cycle. In that case outWord SHALL take the new word and outWordValid SHALL stay 1 (back-to-back, no bubble).
REQ-021 inFlush=1 SHALL clear outCount and the staging register on the next edge.
REQ-022 inFlush SHALL take priority over a simultaneous nibble, which is dropped.
REQ-023 inFlush SHALL NOT affect outWord, outWordValid or a pending output handshake.
REQ-024 inNibValid=1 while outNibReady=0 SHALL leave all state unchanged; upstream holds the nibble.

Reset
REQ-025 With inReset=1 at a rising edge: outWord=0, outWordValid=0, outCount=0, staging register=0.
REQ-026 Reset SHALL take priority over inFlush and all handshakes.
REQ-027 A partial word or pending output at reset SHALL be discarded.
REQ-028 outNibReady SHALL be 1 during the cycle after reset.

Configuration
REQ-029 Macro NIBBLE_PACKER_MSB_FIRST_EN defined: slot k SHALL map to the nibble position counted from the MSB, so the first nibble lands in bits [WORD_WIDTH-1:WORD_WIDTH-4].
REQ-030 Macro NIBBLE_PACKER_MSB_FIRST_EN undefined: the LSB-first mapping of REQ-014 SHALL apply.
REQ-031 The macro SHALL change slot mapping only; timing and handshake behaviour SHALL be identical in both builds.

Structure
REQ-032 A shared package SHALL hold NIBBLE_W=4, the default word width, the count-width function, and a nibble_t typedef.
REQ-033 One sub-module, nibble_slot_writer, SHALL perform the slot-index-to-bit-position write of a nibble into the staging register. It is the inverse of the nibble-select mux.
REQ-034 Counter, handshake and output register SHALL live in the top module.

Verification
REQ-035 Default build, inWordReady=1, nibbles 0x1,0x2,0x3,0x4 on consecutive cycles -> outWord=0x4321 with outWordValid=1 one cycle after the 4th nibble, for exactly one cycle.
REQ-036 NIBBLE_PACKER_MSB_FIRST_EN build, same stimulus -> outWord=0x1234.
REQ-037 Back-pressure: word 0xA5A5 pending with inWordReady=0, then 3 more nibbles -> all accepted (outCount=3), outNibReady=0 for the 4th, outWord holds 0xA5A5; raising inWordReady -> 4th accepted, next word valid with no bubble.
REQ-038 Flush: after 0x7,0x8, assert inFlush together with 0x9 -> outCount=0, 0x9 dropped; then 0xB,0xC,0xD,0xE -> outWord=0xEDCB.
REQ-039 Continuous stream of 8 nibbles 0x0..0x7 with inWordReady=1 -> words 0x3210 and 0x7654 delivered on consecutive word boundaries, with outNibReady never 0.
REQ-040 Reset mid-word (after 2 nibbles) and reset with an output pending -> all outputs 0, outCount=0; next 4 nibbles form a clean word.
